// File: rtl/rvcore_l1_fetch_cache_if.sv
// Fetch-side bus bundle for rvcore_l1_fetch_cache.
// Core side carries line requests and returned 128-bit lines. Memory side carries the
// req/gnt line read and the fill data.
// Modports:
//   slave  - the cache: takes core requests, drives memory requests.
//   master - the environment (core plus memory controller): the opposite directions.
interface rvcore_l1_fetch_cache_if;
  logic         w_core_req;
  logic [31:0]  w_core_addr;
  logic         w_core_nc;
  logic         w_core_ready;
  logic         w_core_rvalid;
  logic [127:0] w_core_rdata;
  logic         w_mem_req;
  logic [31:0]  w_mem_addr;
  logic         w_mem_gnt;
  logic         w_mem_rvalid;
  logic [127:0] w_mem_rdata;

  modport slave (
    input  w_core_req, w_core_addr, w_core_nc, w_mem_gnt, w_mem_rvalid, w_mem_rdata,
    output w_core_ready, w_core_rvalid, w_core_rdata, w_mem_req, w_mem_addr
  );

  modport master (
    output w_core_req, w_core_addr, w_core_nc, w_mem_gnt, w_mem_rvalid, w_mem_rdata,
    input  w_core_ready, w_core_rvalid, w_core_rdata, w_mem_req, w_mem_addr
  );
endinterface

// File: rtl/rvcore_l1_fetch_cache.sv
// Direct-mapped, read-only L1 fetch cache with 16-byte lines.
// Hits answer one cycle after the request. Misses issue a req/gnt line read, then
// return the fill one cycle after it arrives.
// Ports:
//   CLK, RST                   - clock, synchronous active-high reset
//   bus (slave)                - core request/response and memory req/gnt/fill
//   w_cache_invalidate(_address) - single-line invalidate, effective next edge
//   w_flush_all                - clear every valid bit at the next edge
//   w_hit_count, w_miss_count  - statistics, built only with RVCORE_L1_CACHE_STATS_EN
// Build option: define RVCORE_L1_CACHE_STATS_EN to build the hit/miss counters;
// otherwise both count ports are tied to zero.
module rvcore_l1_fetch_cache #(
  parameter int unsigned LINES         = 64,
  parameter int unsigned IDX_W         = $clog2(LINES),
  parameter logic [31:0] RESET_PC_LINE = 32'h0000_1000
) (
  input  logic                          CLK,
  input  logic                          RST,
  rvcore_l1_fetch_cache_if.slave        bus,
  input  logic                          w_cache_invalidate,
  input  logic [31:0]                   w_cache_invalidate_address,
  input  logic                          w_flush_all,
  output logic [31:0]                   w_hit_count,
  output logic [31:0]                   w_miss_count
);
  localparam int unsigned TagW = 28 - IDX_W;

  typedef enum logic [1:0] {StIdle, StMreq, StMwait, StResp} state_e;
  state_e state_q, state_d;

  logic [LINES-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [LINES];
  logic [127:0]     data_q [LINES];
  logic [27:0]      line_q;   // accepted line address, also drives w_mem_addr
  logic             alloc_q;  // outstanding fill may still allocate
  logic             rvalid_q;
  logic [127:0]     rdata_q;

  logic [IDX_W-1:0] req_idx, line_idx, inv_idx;
  logic [TagW-1:0]  req_tag, line_tag, inv_tag;
  logic             accept, hit, inv_req_line, inv_cur_line, fill, fill_we, inv_clr;
  logic             unused_offsets;

  assign req_idx  = bus.w_core_addr[4+IDX_W-1:4];
  assign req_tag  = bus.w_core_addr[31:4+IDX_W];
  assign line_idx = line_q[IDX_W-1:0];
  assign line_tag = line_q[27:IDX_W];
  assign inv_idx  = w_cache_invalidate_address[4+IDX_W-1:4];
  assign inv_tag  = w_cache_invalidate_address[31:4+IDX_W];
  assign unused_offsets = ^{bus.w_core_addr[3:0], w_cache_invalidate_address[3:0]};

  assign accept = (state_q == StIdle) && bus.w_core_req;
  // Uses valid bits from before this edge, so a same-cycle invalidate/flush cannot cancel it.
  assign hit    = accept && !bus.w_core_nc && valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign inv_req_line = w_cache_invalidate && (w_cache_invalidate_address[31:4] == bus.w_core_addr[31:4]);
  assign inv_cur_line = w_cache_invalidate && (w_cache_invalidate_address[31:4] == line_q);

  assign fill    = (state_q == StMwait) && bus.w_mem_rvalid;
  // An invalidate or flush at the fill edge itself also suppresses allocation.
  assign fill_we = fill && alloc_q && !w_flush_all && !inv_cur_line;
  // A fill replacing this index makes the old-tag match meaningless.
  assign inv_clr = w_cache_invalidate && (tag_q[inv_idx] == inv_tag) &&
                   !(fill_we && (inv_idx == line_idx));

  assign bus.w_core_ready  = (state_q == StIdle) && !RST;
  assign bus.w_core_rvalid = rvalid_q;
  assign bus.w_core_rdata  = rdata_q;
  assign bus.w_mem_req     = (state_q == StMreq);
  assign bus.w_mem_addr    = {line_q, 4'b0000};

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept && !hit) state_d = StMreq;
      StMreq:  if (bus.w_mem_gnt) state_d = StMwait;
      StMwait: if (bus.w_mem_rvalid) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      line_q   <= RESET_PC_LINE[31:4];
      alloc_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept) begin
        line_q  <= bus.w_core_addr[31:4];
        alloc_q <= !bus.w_core_nc && !w_flush_all && !inv_req_line;
      end else if (((state_q == StMreq) || (state_q == StMwait)) &&
                   (w_flush_all || inv_cur_line)) begin
        alloc_q <= 1'b0;
      end
      if (hit) begin
        rvalid_q <= 1'b1;
        rdata_q  <= data_q[req_idx];
      end
      if (fill) begin
        rvalid_q <= 1'b1;
        rdata_q  <= bus.w_mem_rdata;
      end
    end
  end

  // Later assignments take priority: invalidate beats fill, flush beats everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      if (fill_we) valid_q[line_idx] <= 1'b1;
      if (inv_clr) valid_q[inv_idx] <= 1'b0;
      if (w_flush_all) valid_q <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (fill_we) begin
      tag_q[line_idx]  <= line_tag;
      data_q[line_idx] <= bus.w_mem_rdata;
    end
  end

`ifdef RVCORE_L1_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
      if (accept && !bus.w_core_nc && !hit) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign w_hit_count  = hit_cnt_q;
  assign w_miss_count = miss_cnt_q;
`else
  assign w_hit_count  = '0;
  assign w_miss_count = '0;
`endif
endmodule

// File: tb/tb_rvcore_l1_fetch_cache.sv
module tb_rvcore_l1_fetch_cache;
`ifdef RVCORE_L1_CACHE_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inv;
  logic [31:0] inv_addr;
  logic        flush;
  logic [31:0] hit_count, miss_count;

  rvcore_l1_fetch_cache_if bus ();

  rvcore_l1_fetch_cache dut (
    .CLK                        (clk),
    .RST                        (rst),
    .bus                        (bus),
    .w_cache_invalidate         (inv),
    .w_cache_invalidate_address (inv_addr),
    .w_flush_all                (flush),
    .w_hit_count                (hit_count),
    .w_miss_count               (miss_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [127:0] exp_q[$];
  int unsigned exp_hits = 0;
  int unsigned exp_misses = 0;

  localparam logic [127:0] D1 = {4{32'hD1D1_0001}};
  localparam logic [127:0] D2 = {4{32'hD2D2_0002}};
  localparam logic [127:0] D3 = {4{32'hD3D3_0003}};
  localparam logic [127:0] D4 = {4{32'hD4D4_0004}};
  localparam logic [127:0] D5 = {4{32'hD5D5_0005}};
  localparam logic [127:0] D6 = {4{32'hD6D6_0006}};
  localparam logic [127:0] D7 = {4{32'hD7D7_0007}};
  localparam logic [127:0] D8 = {4{32'hD8D8_0008}};
  localparam logic [127:0] D9 = {4{32'hD9D9_0009}};

  // Scoreboard: every rvalid pulse must match the oldest pushed expectation.
  always @(negedge clk) begin
    if (bus.w_core_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL rvalid_unexpected got rdata=%h exp no response", bus.w_core_rdata);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        if (bus.w_core_rdata !== e) begin
          failures++;
          $display("FAIL rdata got %h exp %h", bus.w_core_rdata, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check_counters(input string name);
    checks++;
    if (hit_count !== exp_hits) begin
      failures++;
      $display("FAIL %s hit_count got %0d exp %0d", name, hit_count, exp_hits);
    end
    checks++;
    if (miss_count !== exp_misses) begin
      failures++;
      $display("FAIL %s miss_count got %0d exp %0d", name, miss_count, exp_misses);
    end
  endtask

  // One core access; exp_data is the stored line for a hit or the fill data for a miss.
  task automatic access(input logic [31:0] a, input logic nc, input logic [127:0] exp_data,
                        input bit exp_miss, input bit inv_mwait, input bit flush_req,
                        input string name);
    @(negedge clk);
    checks++;
    if (bus.w_core_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_idle got %b exp 1", name, bus.w_core_ready);
    end
    bus.w_core_req  = 1'b1;
    bus.w_core_addr = a;
    bus.w_core_nc   = nc;
    flush = flush_req;
    if (!exp_miss) exp_q.push_back(exp_data);
    if (Stats && !exp_miss) exp_hits++;
    if (Stats && exp_miss && !nc) exp_misses++;
    @(negedge clk);
    bus.w_core_req = 1'b0;
    flush = 1'b0;
    checks++;
    if (bus.w_mem_req !== exp_miss) begin
      failures++;
      $display("FAIL %s mem_req got %b exp %b", name, bus.w_mem_req, exp_miss);
    end
    if (exp_miss) begin
      checks++;
      if (bus.w_mem_addr !== {a[31:4], 4'b0000}) begin
        failures++;
        $display("FAIL %s mem_addr got %h exp %h", name, bus.w_mem_addr, {a[31:4], 4'b0000});
      end
      @(negedge clk);
      checks++;
      if (bus.w_mem_req !== 1'b1 || bus.w_mem_addr !== {a[31:4], 4'b0000}) begin
        failures++;
        $display("FAIL %s mem_hold got req=%b addr=%h exp req=1 addr=%h", name,
                 bus.w_mem_req, bus.w_mem_addr, {a[31:4], 4'b0000});
      end
      bus.w_mem_gnt = 1'b1;
      @(negedge clk);
      bus.w_mem_gnt = 1'b0;
      if (inv_mwait) begin
        inv      = 1'b1;
        inv_addr = a;
      end
      bus.w_mem_rvalid = 1'b1;
      bus.w_mem_rdata  = exp_data;
      exp_q.push_back(exp_data);
      @(negedge clk);
      bus.w_mem_rvalid = 1'b0;
      inv = 1'b0;
      checks++;
      if (bus.w_core_ready !== 1'b0) begin
        failures++;
        $display("FAIL %s ready_resp got %b exp 0", name, bus.w_core_ready);
      end
    end else begin
      checks++;
      if (bus.w_core_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s ready_after_hit got %b exp 1", name, bus.w_core_ready);
      end
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s response_missing got %0d pending exp 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.w_core_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got %b exp 0", bus.w_core_ready);
    end
    @(negedge clk);
    checks++;
    if (bus.w_core_rvalid !== 1'b0 || bus.w_core_rdata !== 128'd0 || bus.w_mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got rvalid=%b rdata=%h mem_req=%b exp 0/0/0",
               bus.w_core_rvalid, bus.w_core_rdata, bus.w_mem_req);
    end
    checks++;
    if (bus.w_mem_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL reset_mem_addr got %h exp 00001000", bus.w_mem_addr);
    end
    check_counters("reset");
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.w_core_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b exp 1", bus.w_core_ready);
    end
  endtask

  task automatic test_miss_hit();
    access(32'h8000_0010, 1'b0, D1, 1'b1, 1'b0, 1'b0, "first_miss");
    access(32'h8000_0010, 1'b0, D1, 1'b0, 1'b0, 1'b0, "first_hit");
    check_counters("miss_hit");
  endtask

  task automatic test_evict();
    access(32'h8000_0410, 1'b0, D2, 1'b1, 1'b0, 1'b0, "evict_miss");
    access(32'h8000_0410, 1'b0, D2, 1'b0, 1'b0, 1'b0, "evict_new_hit");
    access(32'h8000_0010, 1'b0, D1, 1'b1, 1'b0, 1'b0, "evicted_miss");
    access(32'h8000_0010, 1'b0, D1, 1'b0, 1'b0, 1'b0, "refill_hit");
    check_counters("evict");
  endtask

  task automatic test_inval_mwait();
    access(32'h8000_0020, 1'b0, D4, 1'b1, 1'b1, 1'b0, "inval_mwait_fill");
    access(32'h8000_0020, 1'b0, D5, 1'b1, 1'b0, 1'b0, "inval_after_miss");
    access(32'h8000_0020, 1'b0, D5, 1'b0, 1'b0, 1'b0, "inval_refill_hit");
    check_counters("inval");
  endtask

  task automatic test_nc();
    access(32'h8000_0010, 1'b1, D6, 1'b1, 1'b0, 1'b0, "nc_bypass");
    check_counters("nc_no_count");
    access(32'h8000_0010, 1'b0, D1, 1'b0, 1'b0, 1'b0, "nc_line_unchanged");
    check_counters("nc");
  endtask

  task automatic test_flush_hit();
    access(32'h8000_0010, 1'b0, D1, 1'b0, 1'b0, 1'b1, "flush_same_cycle_hit");
    access(32'h8000_0010, 1'b0, D7, 1'b1, 1'b0, 1'b0, "flush_then_miss");
    access(32'h8000_0020, 1'b0, D9, 1'b1, 1'b0, 1'b0, "flush_other_line_miss");
    check_counters("flush");
  endtask

  task automatic test_reset_mid_miss();
    @(negedge clk);
    bus.w_core_req  = 1'b1;
    bus.w_core_addr = 32'h8000_0030;
    bus.w_core_nc   = 1'b0;
    @(negedge clk);
    bus.w_core_req = 1'b0;
    checks++;
    if (bus.w_mem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_mreq got %b exp 1", bus.w_mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.w_mem_req !== 1'b0 || bus.w_core_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_drop got mem_req=%b ready=%b exp 0/0", bus.w_mem_req,
               bus.w_core_ready);
    end
    checks++;
    if (bus.w_mem_addr !== 32'h0000_1000) begin
      failures++;
      $display("FAIL rst_mid_mem_addr got %h exp 00001000", bus.w_mem_addr);
    end
    rst = 1'b0;
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk);
    bus.w_mem_rvalid = 1'b1;
    bus.w_mem_rdata  = D3;
    @(negedge clk);
    bus.w_mem_rvalid = 1'b0;
    check_counters("rst_mid");
    access(32'h8000_0030, 1'b0, D8, 1'b1, 1'b0, 1'b0, "stale_not_allocated");
    access(32'h8000_0010, 1'b0, D7, 1'b1, 1'b0, 1'b0, "reset_cleared_valid");
    access(32'h8000_0030, 1'b0, D8, 1'b0, 1'b0, 1'b0, "post_reset_hit");
    check_counters("post_reset");
  endtask

  initial begin
    rst              = 1'b1;
    inv              = 1'b0;
    inv_addr         = '0;
    flush            = 1'b0;
    bus.w_core_req   = 1'b0;
    bus.w_core_addr  = '0;
    bus.w_core_nc    = 1'b0;
    bus.w_mem_gnt    = 1'b0;
    bus.w_mem_rvalid = 1'b0;
    bus.w_mem_rdata  = '0;
    test_reset();
    test_miss_hit();
    test_evict();
    test_inval_mwait();
    test_nc();
    test_flush_hit();
    test_reset_mid_miss();
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rvcore_l1_fetch_cache.md
Name: rvcore_l1_fetch_cache

Overview:
- Parametrised direct-mapped, read-only L1 cache filling the cached build slot between an RV core's 128-bit line-fetch port and the memory controller.
- Returns a 16-byte line to the core. Hits take 1 cycle; misses go through a req/gnt memory handshake.
- Honours the existing single-line invalidate interface and adds flush-all and non-cacheable bypass.
- Non-cached builds continue to pass through without this block.

Parameters:
- LINES, 64, number of cache lines; power of two, >= 2.
- IDX_W, $clog2(LINES), index width; derived, not overridden.
- RESET_PC_LINE, 32'h0000_1000, value of w_mem_addr at reset (line-aligned).

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- w_core_req  in  1  fetch request, valid only while w_core_ready=1
- w_core_addr  in  32  byte address; bits [3:0] ignored
- w_core_nc  in  1  non-cacheable, sampled with w_core_req
- w_core_ready  out  1  block can accept a request this cycle
- w_core_rvalid  out  1  one-cycle pulse: w_core_rdata valid
- w_core_rdata  out  128  returned line
- w_mem_req  out  1  line read request to memory
- w_mem_addr  out  32  line-aligned address ([3:0]=0)
- w_mem_gnt  in  1  memory accepted request
- w_mem_rvalid  in  1  fill data valid
- w_mem_rdata  in  128  fill line
- w_cache_invalidate  in  1  invalidate one line (pulse)
- w_cache_invalidate_address  in  32  address to invalidate
- w_flush_all  in  1  invalidate all lines (pulse)
- w_hit_count  out  32  see Optional Feature
- w_miss_count  out  32  see Optional Feature

Behaviour:
- Address split: offset [3:0], index [4+IDX_W-1:4], tag [31:4+IDX_W].
- Storage:
  - Valid bits are a flop vector and are cleared by RST.
  - Tag and data arrays are not reset.
- Reset values: w_core_ready=0 while RST, w_core_rvalid=0, w_core_rdata=0, w_mem_req=0, w_mem_addr=RESET_PC_LINE, counters=0, state=IDLE.
- IDLE:
  - w_core_ready=1.
  - On w_core_req at cycle T, latch the address and nc flag.
  - Hit (valid & tag match & !nc): w_core_rvalid=1 at T+1 with the stored line; return to IDLE, so w_core_ready=1 again at T+1.
  - Otherwise go to MREQ.
- MREQ:
  - w_mem_req=1; w_mem_addr={addr[31:4],4'b0} held constant until w_mem_gnt.
  - On gnt, go to MWAIT.
- MWAIT:
  - On w_mem_rvalid, capture w_mem_rdata and go to RESP.
  - If the fill is allocating, write tag/data and set valid on the same edge.
- RESP: w_core_rvalid=1 with the captured line, then IDLE.
- w_core_ready=0 in MREQ, MWAIT and RESP.
- w_mem_rvalid outside MWAIT is ignored.
- Allocation rule: a fill allocates unless any of the following occurred between request accept and fill:
  - nc=1;
  - w_flush_all;
  - w_cache_invalidate to the same line address.
  - Non-allocating fills still return data to the core.
- w_cache_invalidate:
  - Effective in any state at the next edge.
  - Clears valid[index] only if the stored tag matches.
- w_flush_all: clears all valid bits at the next edge, in any state.
- Simultaneous events:
  - The hit decision at accept cycle T uses valid bits before the T edge. An invalidate or flush arriving in cycle T does not cancel that hit response; it does clear the line.
  - A fill write and an invalidate of the same line at the same edge: the invalidate wins (valid=0).
- Reset mid-miss:
  - w_mem_req drops the next cycle and state returns to IDLE.
  - A stale w_mem_rvalid after reset is ignored.
- nc requests never hit, even if a matching valid line exists.

Optional Feature:
- Macro: RVCORE_L1_CACHE_STATS_EN.
- When defined:
  - w_hit_count increments by one per IDLE hit.
  - w_miss_count increments by one per cacheable miss; nc requests are not counted.
  - Both counters wrap modulo 2^32 and are cleared by RST.
- When undefined: both ports are driven constant 0 and no counter flops are built.

Test Plan:
- Reset, then request 0x8000_0010 (cacheable) → w_mem_req=1, w_mem_addr=0x8000_0010; gnt; rvalid with data D1 → w_core_rvalid one cycle later with D1. Repeat the request → rvalid at T+1 with D1, no w_mem_req; counters hit=1, miss=1 (stats build).
- Request 0x8000_0410 with LINES=64 (same index, different tag) → miss, refill with D2. Then 0x8000_0010 → miss again (evicted).
- Issue w_cache_invalidate at 0x8000_0010 during MWAIT of that line's fill → core receives the data; next request to that line misses.
- Request with w_core_nc=1 to a cached, valid line → memory fetch occurs, returned data is from memory, the line is unchanged, counters are unchanged.
- Pulse w_flush_all in the same cycle as a hitting request → hit data returned at T+1; the next request to that line misses.
- Assert RST in MREQ before gnt → w_mem_req=0 the next cycle. A late w_mem_rvalid with data D3 is ignored; no w_core_rvalid and no allocation.
